// File: rtl/apb_req_arbiter_if.sv
// Request/response bundle between two requesters, the arbiter and the APB master.
interface apb_req_arbiter_if;
    // Port 0 / port 1 request side
    logic        tr0;
    logic        tr1;
    logic        write0;
    logic        write1;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic        ready0;
    logic        ready1;
    logic [31:0] rdata0;
    logic [31:0] rdata1;
    logic        busy0;
    logic        busy1;
    logic        err0;
    logic        err1;
    logic        err_clr;

    // APB master internal request side
    logic        m_transfer;
    logic        m_write;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_ready;
    logic [31:0] m_rdata;

    // Environment view: requesters plus the APB master
    modport master (
        output tr0, tr1, write0, write1, addr0, addr1, wdata0, wdata1, err_clr,
        output m_ready, m_rdata,
        input  ready0, ready1, rdata0, rdata1, busy0, busy1, err0, err1,
        input  m_transfer, m_write, m_addr, m_wdata
    );

    // Arbiter view
    modport slave (
        input  tr0, tr1, write0, write1, addr0, addr1, wdata0, wdata1, err_clr,
        input  m_ready, m_rdata,
        output ready0, ready1, rdata0, rdata1, busy0, busy1, err0, err1,
        output m_transfer, m_write, m_addr, m_wdata
    );
endinterface

// File: rtl/apb_req_arbiter.sv
// Two-port arbiter sharing one APB master request interface. Each port owns a
// single pending slot; the FSM grants one slot at a time and returns rdata with
// a one-cycle ready pulse to the owning port.
module apb_req_arbiter #(
    parameter int unsigned PRIO_MODE = 0  // 0: round-robin, 1: port 0 always wins
) (
    input logic              PCLK,
    input logic              PRESET,
    apb_req_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StGrant = 2'd1,
        StWait  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_grant_q;
    logic        winner;
    logic        complete;

    logic [1:0]  tr_in;
    logic [1:0]  write_in;
    logic [31:0] addr_in  [2];
    logic [31:0] wdata_in [2];

    logic [1:0]  valid_q;
    logic [1:0]  slot_write_q;
    logic [31:0] slot_addr_q  [2];
    logic [31:0] slot_wdata_q [2];
    logic [1:0]  ready_q;
    logic [31:0] rdata_q      [2];
    logic [1:0]  err_q;

    assign tr_in       = {bus.tr1, bus.tr0};
    assign write_in    = {bus.write1, bus.write0};
    assign addr_in[0]  = bus.addr0;
    assign addr_in[1]  = bus.addr1;
    assign wdata_in[0] = bus.wdata0;
    assign wdata_in[1] = bus.wdata1;

    // Owner's transfer finishes this cycle; m_ready is ignored in other states
    assign complete = (state_q == StWait) && bus.m_ready;

    // Per-port pending slot, completion pulse, read data and sticky error
    for (genvar i = 0; i < 2; i++) begin : g_port
        localparam logic Idx = 1'(i);

        // Slot capture on an accepted request, release on the owner's completion
        always_ff @(posedge PCLK or negedge PRESET) begin
            if (!PRESET) begin
                valid_q[i]      <= 1'b0;
                slot_write_q[i] <= 1'b0;
                slot_addr_q[i]  <= '0;
                slot_wdata_q[i] <= '0;
            end else if (complete && (owner_q == Idx)) begin
                valid_q[i] <= 1'b0;
            end else if (tr_in[i] && !valid_q[i]) begin
                valid_q[i]      <= 1'b1;
                slot_write_q[i] <= write_in[i];
                slot_addr_q[i]  <= addr_in[i];
                slot_wdata_q[i] <= wdata_in[i];
            end
        end

        // Ready pulse and rdata capture (write completions capture m_rdata too)
        always_ff @(posedge PCLK or negedge PRESET) begin
            if (!PRESET) begin
                ready_q[i] <= 1'b0;
                rdata_q[i] <= '0;
            end else begin
                ready_q[i] <= complete && (owner_q == Idx);
                if (complete && (owner_q == Idx)) begin
                    rdata_q[i] <= bus.m_rdata;
                end
            end
        end

        // Sticky error; a new violation beats a simultaneous clear
        always_ff @(posedge PCLK or negedge PRESET) begin
            if (!PRESET) begin
                err_q[i] <= 1'b0;
            end else if (tr_in[i] && valid_q[i]) begin
                err_q[i] <= 1'b1;
            end else if (bus.err_clr) begin
                err_q[i] <= 1'b0;
            end
        end
    end

    // Winner among valid slots; only meaningful when at least one slot is valid
    always_comb begin
        winner = 1'b0;
        if (PRIO_MODE != 0) begin
            winner = !valid_q[0];
        end else if (valid_q[0] && valid_q[1]) begin
            winner = !last_grant_q;
        end else begin
            winner = valid_q[1];
        end
    end

    // State, owner and last_grant registers
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            if (complete) begin
                last_grant_q <= owner_q;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        unique case (state_q)
            StIdle: begin
                if (|valid_q) begin
                    owner_d = winner;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                state_d = StWait;
            end
            StWait: begin
                if (bus.m_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Master-side outputs; buses are driven from the owner's slot while it holds the grant
    always_comb begin
        bus.m_transfer = 1'b0;
        bus.m_write    = 1'b0;
        bus.m_addr     = '0;
        bus.m_wdata    = '0;
        unique case (state_q)
            StGrant: begin
                bus.m_transfer = 1'b1;
                bus.m_write    = slot_write_q[owner_q];
                bus.m_addr     = slot_addr_q[owner_q];
                bus.m_wdata    = slot_wdata_q[owner_q];
            end
            StWait: begin
                bus.m_write = slot_write_q[owner_q];
                bus.m_addr  = slot_addr_q[owner_q];
                bus.m_wdata = slot_wdata_q[owner_q];
            end
            default: begin
            end
        endcase
    end

    assign bus.ready0 = ready_q[0];
    assign bus.ready1 = ready_q[1];
    assign bus.rdata0 = rdata_q[0];
    assign bus.rdata1 = rdata_q[1];
    assign bus.busy0  = valid_q[0];
    assign bus.busy1  = valid_q[1];
    assign bus.err0   = err_q[0];
    assign bus.err1   = err_q[1];

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench: a round-robin and a fixed-priority arbiter driven with identical
// stimulus from one shared APB master model.
module tb_apb_req_arbiter;

    logic PCLK = 1'b0;
    logic PRESET;

    always #5 PCLK = ~PCLK;

    apb_req_arbiter_if rr_if ();
    apb_req_arbiter_if pr_if ();

    apb_req_arbiter #(.PRIO_MODE(0)) u_rr (.PCLK(PCLK), .PRESET(PRESET), .bus(rr_if));
    apb_req_arbiter #(.PRIO_MODE(1)) u_pr (.PCLK(PCLK), .PRESET(PRESET), .bus(pr_if));

    // Priority instance mirrors every input of the round-robin instance
    assign pr_if.tr0     = rr_if.tr0;
    assign pr_if.tr1     = rr_if.tr1;
    assign pr_if.write0  = rr_if.write0;
    assign pr_if.write1  = rr_if.write1;
    assign pr_if.addr0   = rr_if.addr0;
    assign pr_if.addr1   = rr_if.addr1;
    assign pr_if.wdata0  = rr_if.wdata0;
    assign pr_if.wdata1  = rr_if.wdata1;
    assign pr_if.err_clr = rr_if.err_clr;
    assign pr_if.m_ready = rr_if.m_ready;
    assign pr_if.m_rdata = rr_if.m_rdata;

    int checks   = 0;
    int failures = 0;

    int          slave_wait  = 0;
    logic [31:0] slave_rdata = '0;
    logic [31:0] log0 [64];
    logic [31:0] log1 [64];
    int          n_log0 = 0;
    int          n_log1 = 0;

    typedef struct {
        logic        port;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
        int          exp_ready;  // cycles from the trN cycle to readyN
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // APB master model: m_ready arrives 2 + slave_wait cycles after m_transfer
    initial begin : slave_model
        int          cnt;
        logic        saw;
        logic        active;
        logic        cur_write;
        logic [31:0] cur_addr;
        logic [31:0] cur_wdata;
        cnt = -1;
        active = 1'b0;
        cur_write = 1'b0;
        cur_addr = '0;
        cur_wdata = '0;
        rr_if.m_ready = 1'b0;
        rr_if.m_rdata = '0;
        forever begin
            @(negedge PCLK);
            saw = 1'b0;
            if (PRESET) begin
                if (rr_if.m_transfer) begin
                    saw = 1'b1;
                    active = 1'b1;
                    cur_write = rr_if.m_write;
                    cur_addr = rr_if.m_addr;
                    cur_wdata = rr_if.m_wdata;
                    if (n_log0 < 64) log0[n_log0] = rr_if.m_addr;
                    n_log0++;
                end else if (active) begin
                    chk("wait_stable_addr", rr_if.m_addr, cur_addr);
                    chk("wait_stable_wdata", rr_if.m_wdata, cur_wdata);
                    chk("wait_stable_write", 32'(rr_if.m_write), 32'(cur_write));
                end
                if (pr_if.m_transfer) begin
                    if (n_log1 < 64) log1[n_log1] = pr_if.m_addr;
                    n_log1++;
                end
            end
            @(posedge PCLK);
            #2;
            if (rr_if.m_ready) begin
                rr_if.m_ready = 1'b0;
                active = 1'b0;
            end
            if (!PRESET) begin
                cnt = -1;
                active = 1'b0;
            end else if (saw) begin
                cnt = 1 + slave_wait;
            end else if (cnt > 0) begin
                cnt--;
            end
            if (cnt == 0) begin
                rr_if.m_ready = 1'b1;
                rr_if.m_rdata = slave_rdata;
                cnt = -1;
            end
        end
    end

    task automatic drive0(input logic w, input logic [31:0] a, input logic [31:0] d);
        rr_if.tr0 = 1'b1;
        rr_if.write0 = w;
        rr_if.addr0 = a;
        rr_if.wdata0 = d;
    endtask

    task automatic drive1(input logic w, input logic [31:0] a, input logic [31:0] d);
        rr_if.tr1 = 1'b1;
        rr_if.write1 = w;
        rr_if.addr1 = a;
        rr_if.wdata1 = d;
    endtask

    task automatic clear_tr();
        rr_if.tr0 = 1'b0;
        rr_if.tr1 = 1'b0;
    endtask

    // Entered and left at posedge+1
    task automatic reset_dut();
        PRESET = 1'b0;
        repeat (2) @(posedge PCLK);
        #1 PRESET = 1'b1;
    endtask

    // Runs until both ports are idle; entered after the request cycle
    task automatic wait_done(input string name);
        logic done;
        done = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge PCLK);
            if (!rr_if.busy0 && !rr_if.busy1) done = 1'b1;
            @(posedge PCLK);
            #1;
            if (done) break;
        end
        if (!done) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    // One uncontended transfer with latency and data checks
    task automatic run_vec(input vec_t v, input string name);
        int          xfer_at;
        int          ready_at;
        int          busy_first;
        int          busy_last;
        logic [31:0] rd;
        logic        other_ready;
        xfer_at = -1;
        ready_at = -1;
        busy_first = -1;
        busy_last = -1;
        rd = '0;
        other_ready = 1'b0;
        slave_wait = v.waits;
        slave_rdata = v.rdata;
        if (v.port) drive1(v.write, v.addr, v.wdata);
        else        drive0(v.write, v.addr, v.wdata);
        for (int k = 0; k < 40; k++) begin
            @(negedge PCLK);
            if (rr_if.m_transfer && xfer_at < 0) xfer_at = k;
            if (v.port ? rr_if.busy1 : rr_if.busy0) begin
                if (busy_first < 0) busy_first = k;
                busy_last = k;
            end
            if (v.port ? rr_if.ready0 : rr_if.ready1) other_ready = 1'b1;
            if (v.port ? rr_if.ready1 : rr_if.ready0) begin
                ready_at = k;
                rd = v.port ? rr_if.rdata1 : rr_if.rdata0;
            end
            @(posedge PCLK);
            #1;
            if (k == 0) clear_tr();
            if (ready_at >= 0) break;
        end
        chk({name, "_xfer_cycle"}, 32'(xfer_at), 32'd2);
        chk({name, "_ready_cycle"}, 32'(ready_at), 32'(v.exp_ready));
        chk({name, "_rdata"}, rd, v.rdata);
        chk({name, "_busy_rise"}, 32'(busy_first), 32'd1);
        chk({name, "_busy_last"}, 32'(busy_last), 32'(v.exp_ready - 1));
        chk({name, "_other_ready"}, 32'(other_ready), 32'd0);
        @(negedge PCLK);
        chk({name, "_ready_single"}, 32'(v.port ? rr_if.ready1 : rr_if.ready0), 32'd0);
        @(posedge PCLK);
        #1;
    endtask

    initial begin : main
        int   base0;
        int   base1;
        int   n0;
        int   n1;
        logic seen;

        vecs[0] = '{1'b0, 1'b0, 32'h1000_2004, 32'h0000_0000, 32'hDEAD_BEEF, 0, 5};
        vecs[1] = '{1'b1, 1'b1, 32'h1000_4000, 32'h0000_0055, 32'h0000_1234, 3, 8};
        vecs[2] = '{1'b1, 1'b0, 32'h2000_0010, 32'h0000_0000, 32'hA5A5_0F0F, 1, 6};
        vecs[3] = '{1'b0, 1'b1, 32'h1000_0008, 32'hCAFE_F00D, 32'h0000_0000, 2, 7};

        PRESET = 1'b0;
        rr_if.tr0 = 1'b0;
        rr_if.tr1 = 1'b0;
        rr_if.write0 = 1'b0;
        rr_if.write1 = 1'b0;
        rr_if.addr0 = '0;
        rr_if.addr1 = '0;
        rr_if.wdata0 = '0;
        rr_if.wdata1 = '0;
        rr_if.err_clr = 1'b0;
        repeat (3) @(posedge PCLK);
        #1 PRESET = 1'b1;

        // Reset values
        @(negedge PCLK);
        chk("rst_busy", 32'({rr_if.busy1, rr_if.busy0}), 32'd0);
        chk("rst_ready", 32'({rr_if.ready1, rr_if.ready0}), 32'd0);
        chk("rst_err", 32'({rr_if.err1, rr_if.err0}), 32'd0);
        chk("rst_m_ctrl", 32'({rr_if.m_transfer, rr_if.m_write}), 32'd0);
        chk("rst_m_addr", rr_if.m_addr, 32'd0);
        chk("rst_m_wdata", rr_if.m_wdata, 32'd0);
        chk("rst_rdata0", rr_if.rdata0, 32'd0);
        chk("rst_rdata1", rr_if.rdata1, 32'd0);
        @(posedge PCLK);
        #1;

        for (int i = 0; i < 4; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Simultaneous requests: round-robin alternates on last completed port
        reset_dut();
        slave_wait = 0;
        slave_rdata = 32'h0000_0001;
        base0 = n_log0;
        base1 = n_log1;
        drive0(1'b0, 32'h3000_0000, '0);
        drive1(1'b0, 32'h3100_0000, '0);
        @(posedge PCLK);
        #1 clear_tr();
        wait_done("sim1");
        // A lone port 0 completion leaves last_grant = 0
        drive0(1'b0, 32'h3000_0000, '0);
        @(posedge PCLK);
        #1 clear_tr();
        wait_done("lone0");
        drive0(1'b0, 32'h3000_0000, '0);
        drive1(1'b0, 32'h3100_0000, '0);
        @(posedge PCLK);
        #1 clear_tr();
        wait_done("sim2");
        chk("rr_count", 32'(n_log0 - base0), 32'd5);
        chk("rr_sim1_first", log0[base0 + 0], 32'h3000_0000);
        chk("rr_sim1_second", log0[base0 + 1], 32'h3100_0000);
        chk("rr_sim2_first", log0[base0 + 3], 32'h3100_0000);
        chk("rr_sim2_second", log0[base0 + 4], 32'h3000_0000);
        chk("pr_count", 32'(n_log1 - base1), 32'd5);
        chk("pr_sim1_first", log1[base1 + 0], 32'h3000_0000);
        chk("pr_sim2_first", log1[base1 + 3], 32'h3000_0000);
        chk("pr_sim2_second", log1[base1 + 4], 32'h3100_0000);

        // Protocol violation on port 0, plus a clear racing a new error
        base0 = n_log0;
        slave_wait = 0;
        drive0(1'b0, 32'h1000_0100, '0);
        @(posedge PCLK);
        #1 drive0(1'b0, 32'h1000_1000, '0);
        @(posedge PCLK);
        #1 rr_if.err_clr = 1'b1;
        @(negedge PCLK);
        chk("viol_err0_set", 32'(rr_if.err0), 32'd1);
        @(posedge PCLK);
        #1 clear_tr();
        rr_if.err_clr = 1'b0;
        @(negedge PCLK);
        chk("viol_err_beats_clr", 32'(rr_if.err0), 32'd1);
        @(posedge PCLK);
        #1;
        wait_done("viol");
        chk("viol_count", 32'(n_log0 - base0), 32'd1);
        chk("viol_orig_addr", log0[base0], 32'h1000_0100);
        chk("viol_err0_sticky", 32'(rr_if.err0), 32'd1);
        chk("viol_err1", 32'(rr_if.err1), 32'd0);
        rr_if.err_clr = 1'b1;
        @(posedge PCLK);
        #1 rr_if.err_clr = 1'b0;
        @(negedge PCLK);
        chk("viol_err0_cleared", 32'(rr_if.err0), 32'd0);
        @(posedge PCLK);
        #1;

        // Streaming: port 0 reissues in each ready0 cycle while port 1 waits
        reset_dut();
        base0 = n_log0;
        slave_wait = 0;
        n0 = 0;
        n1 = 0;
        drive0(1'b0, 32'h5000_0000, '0);
        drive1(1'b0, 32'h5100_0000, '0);
        for (int k = 0; k < 300; k++) begin
            @(posedge PCLK);
            #1 clear_tr();
            @(negedge PCLK);
            if (rr_if.ready1) n1++;
            if (rr_if.ready0) begin
                n0++;
                if (n0 < 4) drive0(1'b0, 32'h5000_0000 + 32'(n0 * 4), '0);
            end
            if (n0 == 4 && n1 == 1) break;
        end
        @(posedge PCLK);
        #1 clear_tr();
        chk("stream_n0", 32'(n0), 32'd4);
        chk("stream_n1", 32'(n1), 32'd1);
        chk("stream_count", 32'(n_log0 - base0), 32'd5);
        chk("stream_g0", log0[base0 + 0], 32'h5000_0000);
        chk("stream_g1", log0[base0 + 1], 32'h5100_0000);
        chk("stream_g2", log0[base0 + 2], 32'h5000_0004);
        chk("stream_g3", log0[base0 + 3], 32'h5000_0008);
        chk("stream_g4", log0[base0 + 4], 32'h5000_000C);
        chk("stream_err0", 32'(rr_if.err0), 32'd0);

        // Reset asserted while port 1 sits in WAIT
        slave_wait = 3;
        seen = 1'b0;
        drive1(1'b0, 32'h4000_0000, '0);
        for (int k = 0; k < 20; k++) begin
            @(negedge PCLK);
            if (rr_if.m_transfer) seen = 1'b1;
            @(posedge PCLK);
            #1 clear_tr();
            if (seen) break;
        end
        chk("rstw_saw_xfer", 32'(seen), 32'd1);
        @(posedge PCLK);
        #1 PRESET = 1'b0;
        @(negedge PCLK);
        chk("rstw_busy", 32'({rr_if.busy1, rr_if.busy0}), 32'd0);
        chk("rstw_ready", 32'({rr_if.ready1, rr_if.ready0}), 32'd0);
        chk("rstw_m_ctrl", 32'({rr_if.m_transfer, rr_if.m_write}), 32'd0);
        chk("rstw_m_addr", rr_if.m_addr, 32'd0);
        chk("rstw_rdata", rr_if.rdata0 | rr_if.rdata1, 32'd0);
        @(posedge PCLK);
        #1 PRESET = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge PCLK);
            if (rr_if.ready1 || rr_if.ready0) seen = 1'b1;
        end
        chk("rstw_no_ready", 32'(seen), 32'd0);
        @(posedge PCLK);
        #1;
        run_vec(vecs[1], "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
